pwm_peripheral: RTL and testbench

Consumes the five configuration registers written over SPI (`en_reg_out_*`, `en_reg_pwm_*`, `pwm_duty_cycle`) and drives the 16 chip outputs.

- Each output is forced low, forced high, or driven by a shared 8-bit PWM waveform.
- The duty cycle is double-buffered and takes effect only at a period boundary, so writes arriving mid-period never produce a glitched pulse.
- Sits directly downstream of the SPI register block and directly upstream of the output pads.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_prescaler.sv | 29 ++
 rtl/pwm_peripheral.sv | 81 ++++++++
 tb/tb_pwm_peripheral.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, duty constants and output-select helper for the PWM peripheral
package pwm_pkg;

    localparam int PWM_WIDTH   = 8;
    localparam int NUM_OUTPUTS = 16;

    localparam logic [PWM_WIDTH-1:0] DUTY_OFF  = 8'h00;
    localparam logic [PWM_WIDTH-1:0] DUTY_FULL = 8'hFF;

    typedef logic [PWM_WIDTH-1:0]   pwm_cnt_t;
    typedef logic [NUM_OUTPUTS-1:0] out_vec_t;

    // Disabled outputs are low regardless of the PWM select bit.
    function automatic out_vec_t select_outputs(input out_vec_t en_out,
                                                input out_vec_t en_pwm,
                                                input logic     level);
        return en_out & ((en_pwm & {NUM_OUTPUTS{level}}) | ~en_pwm);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - divides clk by CLK_DIV, one-cycle tick on the last count
module pwm_prescaler #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-output driver: static low/high or shared 8-bit PWM with period-aligned duty updates
module pwm_peripheral import pwm_pkg::*; #(
    parameter int CLK_DIV = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] out_7_0,
    output logic [7:0] out_15_8,
    output logic       period_start
);

    localparam pwm_cnt_t CNT_LAST = '1;

    logic     w_tick;
    logic     w_level;
    logic     w_period_boundary;
    out_vec_t w_en_out;
    out_vec_t w_en_pwm;
    out_vec_t w_out_next;

    logic     r_pre_zero;
    pwm_cnt_t r_counter;
    pwm_cnt_t r_duty_shadow;
    out_vec_t r_out;
    logic     r_period_start;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // The prescaler is at zero exactly in the cycle after a tick (or right after reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_zero <= 1'b1;
        end else begin
            r_pre_zero <= w_tick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counter     <= '0;
            r_duty_shadow <= DUTY_OFF;
        end else if (w_tick) begin
            r_counter <= r_counter + pwm_cnt_t'(1);
            if (r_counter == CNT_LAST) begin
                r_duty_shadow <= pwm_duty_cycle;
            end
        end
    end

    assign w_level           = (r_duty_shadow == DUTY_FULL) || (r_counter < r_duty_shadow);
    assign w_period_boundary = r_pre_zero && (r_counter == '0);
    assign w_en_out          = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm          = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_out_next        = select_outputs(w_en_out, w_en_pwm, w_level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_out_next;
            r_period_start <= w_period_boundary;
        end
    end

    assign out_7_0      = r_out[7:0];
    assign out_15_8     = r_out[15:8];
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - self-checking bench for pwm_peripheral at CLK_DIV=13 and CLK_DIV=1
module tb_pwm_peripheral;

    localparam int D  = 13;
    localparam int P  = 256 * D;
    localparam int P1 = 256;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] en_out = 16'hFFFF;
    logic [15:0] en_pwm = 16'h0000;
    logic [7:0]  duty   = 8'h00;
    logic [7:0]  duty1  = 8'h03;

    logic [7:0] o70, o158, o70b, o158b;
    logic       ps, ps1;

    int tests = 0;
    int fails = 0;
    int mism  = 0;
    int hi, tg, pc;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(D)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out_7_0         (o70),
        .out_15_8        (o158),
        .period_start    (ps)
    );

    pwm_peripheral #(.CLK_DIV(1)) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty1),
        .out_7_0         (o70b),
        .out_15_8        (o158b),
        .period_start    (ps1)
    );

    // Reference: output for elapsed time t since reset, from the period/phase arithmetic.
    function automatic logic [15:0] ref_out(input int t, input int div, input logic [7:0] sh,
                                            input logic [15:0] eo, input logic [15:0] ep);
        int          cnt;
        logic        lvl;
        logic [15:0] r;
        cnt = (t % (256 * div)) / div;
        lvl = (sh == 8'hFF) || (cnt < int'(sh));
        for (int i = 0; i < 16; i++) r[i] = eo[i] ? (ep[i] ? lvl : 1'b1) : 1'b0;
        return r;
    endfunction

    int          m_t;
    logic [7:0]  m_sh, m_sh1;
    logic [15:0] e_out, e_out1;
    logic        e_ps, e_ps1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0; m_sh <= 8'h00; m_sh1 <= 8'h00;
            e_out <= '0; e_out1 <= '0; e_ps <= 1'b0; e_ps1 <= 1'b0;
        end else begin
            e_out  <= ref_out(m_t, D, m_sh, en_out, en_pwm);
            e_out1 <= ref_out(m_t, 1, m_sh1, en_out, en_pwm);
            e_ps   <= (m_t % P == 0);
            e_ps1  <= (m_t % P1 == 0);
            if (m_t % P == P - 1)   m_sh  <= duty;
            if (m_t % P1 == P1 - 1) m_sh1 <= duty1;
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if ({o158, o70} !== e_out || ps !== e_ps || {o158b, o70b} !== e_out1 || ps1 !== e_ps1) begin
                if (mism == 0)
                    $display("[TB] first model divergence at t=%0d: out=%h/%h ps=%b/%b out1=%h/%h ps1=%b/%b",
                             m_t, {o158, o70}, e_out, ps, e_ps, {o158b, o70b}, e_out1, ps1, e_ps1);
                mism++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ps(input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (ps !== 1'b1 && k < 2 * P);
        chk(tag, {31'd0, ps}, 32'd1);
    endtask

    task automatic wait_ps1(input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (ps1 !== 1'b1 && k < 2 * P1);
        chk(tag, {31'd0, ps1}, 32'd1);
    endtask

    task automatic set_duty(input logic [7:0] d);
        wait_ps("sync_period");
        duty = d;
        wait_ps("duty_loaded_period");
    endtask

    // Samples o70[0] for n cycles starting with the current sample.
    task automatic measure(input int n, output int h, output int toggles);
        logic prev;
        prev = o70[0]; h = (o70[0] === 1'b1) ? 1 : 0; toggles = 0;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            if (o70[0] === 1'b1) h++;
            if (o70[0] !== prev) toggles++;
            prev = o70[0];
        end
    endtask

    task automatic measure1(input int n, output int h, output int pcount);
        h = (o70b[0] === 1'b1) ? 1 : 0; pcount = (ps1 === 1'b1) ? 1 : 0;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            if (o70b[0] === 1'b1) h++;
            if (ps1 === 1'b1) pcount++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_out",  {16'd0, o158, o70},   32'd0);
        chk("reset_ps",   {31'd0, ps},          32'd0);
        chk("reset_out1", {16'd0, o158b, o70b}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_out", {16'd0, o158, o70}, 32'h0000FFFF);

        repeat (1500) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out", {16'd0, o158, o70}, 32'd0);
        chk("mid_reset_ps",  {31'd0, ps},        32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_out", {16'd0, o158, o70}, 32'h0000FFFF);

        en_pwm = 16'h0001;
        wait_ps1("div1_period");
        measure1(P1, hi, pc);
        chk("div1_high_cycles", hi, 3);
        chk("div1_ps_count", pc, 1);
        @(negedge clk);
        chk("div1_ps_spacing", {31'd0, ps1}, 32'd1);

        en_out = 16'h0001;
        set_duty(8'h80);
        chk("d80_rise_at_ps", {31'd0, o70[0]}, 32'd1);
        measure(P, hi, tg);
        chk("d80_high", hi, 1664);
        chk("d80_toggles", tg, 1);

        set_duty(8'hFF);
        measure(3 * P, hi, tg);
        chk("dFF_high", hi, 3 * P);
        chk("dFF_toggles", tg, 0);

        set_duty(8'h00);
        measure(P, hi, tg);
        chk("d00_high", hi, 0);

        set_duty(8'h01);
        chk("d01_rise_at_ps", {31'd0, o70[0]}, 32'd1);
        measure(P, hi, tg);
        chk("d01_high", hi, 13);
        chk("d01_toggles", tg, 1);

        set_duty(8'h40);
        measure(1000, hi, tg);
        chk("mid_first_high", hi, 832);
        duty = 8'hC0;
        @(negedge clk);
        measure(P - 1000, hi, tg);
        chk("mid_rest_high", hi, 0);
        chk("mid_rest_toggles", tg, 0);
        @(negedge clk);
        chk("mid_next_ps", {31'd0, ps}, 32'd1);
        measure(P, hi, tg);
        chk("mid_next_high", hi, 2496);
        chk("mid_next_toggles", tg, 1);
        chk("model_directed", mism, 0);

        en_out = 16'hA5F0;
        en_pwm = 16'h00F0;
        set_duty(8'h40);
        chk("mixed_at_ps", {16'd0, o158, o70}, 32'h0000A5F0);
        repeat (900) @(negedge clk);
        chk("mixed_low_phase", {16'd0, o158, o70}, 32'h0000A500);
        en_out[15] = 1'b0;
        @(negedge clk);
        chk("mixed_en15_off", {24'd0, o158}, 32'h00000025);

        for (int k = 0; k < 2 * P; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 499) == 0) duty   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99)  == 0) duty1  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) en_out = 16'($urandom);
            if ($urandom_range(0, 199) == 0) en_pwm = 16'($urandom);
        end
        chk("model_random", mism, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
